// File: rtl/hazard_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_pkg
// Shared definitions for the pipeline hazard controller:
//   - forwarding mux select codes (common to all four operand muxes)
//   - mult/div sequencer state encoding
//   - default mult/div busy lengths
//   - producer/source match helper
// -----------------------------------------------------------------------------
package hazard_ctrl_pkg;

   localparam logic [1:0] FWD_RF = 2'b00;  // register file / pipeline value
   localparam logic [1:0] FWD_M  = 2'b01;  // M-stage result
   localparam logic [1:0] FWD_W  = 2'b10;  // W-stage result
   localparam logic [1:0] FWD_E  = 2'b11;  // E-stage result (D muxes only)

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_MULT = 2'd1,
      MD_DIV  = 2'd2
   } md_state_t;

   // A producer supplies a source only if it writes, targets that register,
   // and the register is not $0 ($0 is hardwired and never forwarded).
   function automatic logic src_match(input logic       wr_en,
                                      input logic [4:0] wa,
                                      input logic [4:0] src);
      return wr_en && (wa == src) && (src != 5'd0);
   endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_if
// Bundle of pipeline-stage information into the hazard controller and the
// forwarding/stall controls back out.
//   master : pipeline side (drives stage info, receives controls)
//   slave  : hazard controller
// -----------------------------------------------------------------------------
interface hazard_ctrl_if;

   // D stage
   logic [4:0] d_rs, d_rt;
   logic       d_rs_used, d_rt_used;
   logic       d_rs_now, d_rt_n_now;
   logic       d_is_md;
   // E stage
   logic [4:0] e_rs, e_rt;
   logic [4:0] e_wa;
   logic       e_wr_en;
   logic       e_res_ready;
   logic       e_is_load;
   logic       start_mult, start_div;
   // M / W stages
   logic [4:0] m_wa, w_wa;
   logic       m_wr_en, w_wr_en;
   logic       m_is_load;
   // controls
   logic [1:0] fwd_d_rs_sel, fwd_d_rt_sel;
   logic [1:0] fwd_e_rs_sel, fwd_e_rt_sel;
   logic       stall;
   logic       flush_e;
   logic       md_busy;

   modport master (
      output d_rs, d_rt, d_rs_used, d_rt_used, d_rs_now, d_rt_n_now, d_is_md,
             e_rs, e_rt, e_wa, e_wr_en, e_res_ready, e_is_load,
             start_mult, start_div,
             m_wa, w_wa, m_wr_en, w_wr_en, m_is_load,
      input  fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel,
             stall, flush_e, md_busy
   );

   modport slave (
      input  d_rs, d_rt, d_rs_used, d_rt_used, d_rs_now, d_rt_n_now, d_is_md,
             e_rs, e_rt, e_wa, e_wr_en, e_res_ready, e_is_load,
             start_mult, start_div,
             m_wa, w_wa, m_wr_en, w_wr_en, m_is_load,
      output fwd_d_rs_sel, fwd_d_rt_sel, fwd_e_rs_sel, fwd_e_rt_sel,
             stall, flush_e, md_busy
   );

endinterface

// File: rtl/hazard_ctrl_md_seq.sv
// -----------------------------------------------------------------------------
// md_seq
// Busy sequencer for the iterative mult/div unit. A start pulse in IDLE loads
// the down-counter with the operation length; the unit reports busy until the
// counter has run down to 1, then returns to IDLE on the following edge.
// Starts while busy are ignored (no reload).
// Ports:
//   clk, reset_n           clock, async active-low reset
//   start_mult, start_div  one-cycle issue pulses from E (div wins if both)
//   md_busy                registered, high while not IDLE
// -----------------------------------------------------------------------------
module md_seq
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset_n,
   input  logic start_mult,
   input  logic start_div,
   output logic md_busy
);

   localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] MULT_LD = CW'(MULT_CYCLES);
   localparam logic [CW-1:0] DIV_LD  = CW'(DIV_CYCLES);
   localparam logic [CW-1:0] ONE     = CW'(1);

   md_state_t     state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state   <= MD_IDLE;
         cnt     <= '0;
         md_busy <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         md_busy <= (state_nx != MD_IDLE);
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      case (state)
         MD_IDLE: begin
            if (start_div) begin
               state_nx = MD_DIV;
               cnt_nx   = DIV_LD;
            end else if (start_mult) begin
               state_nx = MD_MULT;
               cnt_nx   = MULT_LD;
            end
         end
         MD_MULT, MD_DIV: begin
            // cnt==1 is the last busy cycle; <= also recovers from a zero count
            if (cnt <= ONE) begin
               state_nx = MD_IDLE;
               cnt_nx   = '0;
            end else begin
               cnt_nx = cnt - ONE;
            end
         end
         default: begin
            state_nx = MD_IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

endmodule

// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
// Hazard controller for the five-stage MIPS pipeline.
//   - picks forwarding mux selects for the D-stage and E-stage operand muxes
//     (nearest producer first: E (D only, result ready), M (not a load), W)
//   - raises stall / flush_e on load-use, branch-operand and HI/LO conflicts
//   - hosts the mult/div busy sequencer (md_seq)
// Ports:
//   clk, reset_n   clock, async active-low reset
//   hz (slave)     stage info in; forwarding selects, stall, flush_e, md_busy out
// Everything except md_busy is combinational.
// -----------------------------------------------------------------------------
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic         clk,
   input  logic         reset_n,
   hazard_ctrl_if.slave hz
);

   logic md_busy_q;
   logic stall_lu, stall_br, stall_md;

   md_seq #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_seq (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_mult (hz.start_mult),
      .start_div  (hz.start_div),
      .md_busy    (md_busy_q)
   );

   assign hz.md_busy = md_busy_q;

   // D-stage select: E result only when already computed in E; a load in M
   // has no data yet, so it is skipped (the stall logic covers that case).
   function automatic logic [1:0] d_sel(input logic [4:0] src,
                                        input logic       e_ok,
                                        input logic [4:0] e_wa,
                                        input logic       m_ok,
                                        input logic [4:0] m_wa,
                                        input logic       w_ok,
                                        input logic [4:0] w_wa);
      if (src_match(e_ok, e_wa, src))      return FWD_E;
      else if (src_match(m_ok, m_wa, src)) return FWD_M;
      else if (src_match(w_ok, w_wa, src)) return FWD_W;
      else                                 return FWD_RF;
   endfunction

   // E-stage select: the E result is this instruction's own, so only M/W.
   function automatic logic [1:0] e_sel(input logic [4:0] src,
                                        input logic       m_ok,
                                        input logic [4:0] m_wa,
                                        input logic       w_ok,
                                        input logic [4:0] w_wa);
      if (src_match(m_ok, m_wa, src))      return FWD_M;
      else if (src_match(w_ok, w_wa, src)) return FWD_W;
      else                                 return FWD_RF;
   endfunction

   logic e_fwd_ok, m_fwd_ok, e_pending, m_ld_pending;

   assign e_fwd_ok     = hz.e_wr_en && hz.e_res_ready;
   assign m_fwd_ok     = hz.m_wr_en && !hz.m_is_load;
   assign e_pending    = hz.e_wr_en && !hz.e_res_ready;
   assign m_ld_pending = hz.m_wr_en && hz.m_is_load;

   always_comb begin
      hz.fwd_d_rs_sel = d_sel(hz.d_rs, e_fwd_ok, hz.e_wa, m_fwd_ok, hz.m_wa,
                              hz.w_wr_en, hz.w_wa);
      hz.fwd_d_rt_sel = d_sel(hz.d_rt, e_fwd_ok, hz.e_wa, m_fwd_ok, hz.m_wa,
                              hz.w_wr_en, hz.w_wa);
      hz.fwd_e_rs_sel = e_sel(hz.e_rs, m_fwd_ok, hz.m_wa, hz.w_wr_en, hz.w_wa);
      hz.fwd_e_rt_sel = e_sel(hz.e_rt, m_fwd_ok, hz.m_wa, hz.w_wr_en, hz.w_wa);
   end

   // load in E feeding any D source: data arrives no earlier than W
   assign stall_lu = hz.e_is_load &&
                     ((hz.d_rs_used && src_match(hz.e_wr_en, hz.e_wa, hz.d_rs)) ||
                      (hz.d_rt_used && src_match(hz.e_wr_en, hz.e_wa, hz.d_rt)));

   // operand consumed in D but its producer has no value yet
   assign stall_br = (hz.d_rs_now &&
                      (src_match(e_pending, hz.e_wa, hz.d_rs) ||
                       src_match(m_ld_pending, hz.m_wa, hz.d_rs))) ||
                     (hz.d_rt_n_now &&
                      (src_match(e_pending, hz.e_wa, hz.d_rt) ||
                       src_match(m_ld_pending, hz.m_wa, hz.d_rt)));

   // start pulses count too so HI/LO access in the issue cycle is held
   assign stall_md = hz.d_is_md && (md_busy_q || hz.start_mult || hz.start_div);

   assign hz.stall   = stall_lu || stall_br || stall_md;
   assign hz.flush_e = hz.stall;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed testbench for hazard_ctrl: forwarding priority, $0 guard, load-use,
// branch-operand stall, mult/div sequencing and asynchronous reset.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic clk;
   logic reset_n;
   int   checks;
   int   errors;

   hazard_ctrl_if hz ();

   hazard_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .hz      (hz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic clr_inputs();
      hz.d_rs = 5'd0; hz.d_rt = 5'd0;
      hz.d_rs_used = 1'b0; hz.d_rt_used = 1'b0;
      hz.d_rs_now = 1'b0; hz.d_rt_n_now = 1'b0;
      hz.d_is_md = 1'b0;
      hz.e_rs = 5'd0; hz.e_rt = 5'd0; hz.e_wa = 5'd0;
      hz.e_wr_en = 1'b0; hz.e_res_ready = 1'b0; hz.e_is_load = 1'b0;
      hz.start_mult = 1'b0; hz.start_div = 1'b0;
      hz.m_wa = 5'd0; hz.w_wa = 5'd0;
      hz.m_wr_en = 1'b0; hz.w_wr_en = 1'b0; hz.m_is_load = 1'b0;
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      clr_inputs();
      #3;
      checks++;
      if (hz.md_busy !== 1'b0) begin
         errors++; $display("FAIL reset_md_busy: got %b expected 0", hz.md_busy);
      end
      checks++;
      if ({hz.stall, hz.flush_e} !== 2'b00) begin
         errors++; $display("FAIL reset_stall_flush: got %b expected 00", {hz.stall, hz.flush_e});
      end
      checks++;
      if ({hz.fwd_d_rs_sel, hz.fwd_d_rt_sel, hz.fwd_e_rs_sel, hz.fwd_e_rt_sel} !== 8'h00) begin
         errors++; $display("FAIL reset_fwd_sels: got %h expected 00",
                            {hz.fwd_d_rs_sel, hz.fwd_d_rt_sel, hz.fwd_e_rs_sel, hz.fwd_e_rt_sel});
      end
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      checks++;
      if (hz.md_busy !== 1'b0) begin
         errors++; $display("FAIL reset_release_idle: got %b expected 0", hz.md_busy);
      end
   endtask

   task automatic test_fwd_priority();
      @(negedge clk);
      clr_inputs();
      hz.m_wr_en = 1'b1; hz.m_wa = 5'd8;
      hz.w_wr_en = 1'b1; hz.w_wa = 5'd8;
      hz.e_rs = 5'd8;
      hz.d_rs = 5'd8; hz.d_rs_used = 1'b1;
      #1;
      checks++;
      if (hz.fwd_e_rs_sel !== 2'b01) begin
         errors++; $display("FAIL fwd_e_rs_m_over_w: got %b expected 01", hz.fwd_e_rs_sel);
      end
      checks++;
      if (hz.fwd_d_rs_sel !== 2'b01) begin
         errors++; $display("FAIL fwd_d_rs_m_over_w: got %b expected 01", hz.fwd_d_rs_sel);
      end
      hz.m_wr_en = 1'b0;
      #1;
      checks++;
      if (hz.fwd_e_rs_sel !== 2'b10) begin
         errors++; $display("FAIL fwd_e_rs_w_only: got %b expected 10", hz.fwd_e_rs_sel);
      end
      // M holds a load to $8: skipped, W supplies
      hz.m_wr_en = 1'b1; hz.m_is_load = 1'b1;
      hz.e_rt = 5'd8;
      #1;
      checks++;
      if (hz.fwd_e_rt_sel !== 2'b10) begin
         errors++; $display("FAIL fwd_e_rt_skip_m_load: got %b expected 10", hz.fwd_e_rt_sel);
      end
      // E ready result wins for D, but E muxes never pick E
      hz.m_is_load = 1'b0;
      hz.e_wr_en = 1'b1; hz.e_wa = 5'd8; hz.e_res_ready = 1'b1;
      #1;
      checks++;
      if (hz.fwd_d_rs_sel !== 2'b11) begin
         errors++; $display("FAIL fwd_d_rs_e_ready: got %b expected 11", hz.fwd_d_rs_sel);
      end
      checks++;
      if (hz.fwd_e_rs_sel !== 2'b01) begin
         errors++; $display("FAIL fwd_e_rs_no_e: got %b expected 01", hz.fwd_e_rs_sel);
      end
      checks++;
      if (hz.stall !== 1'b0) begin
         errors++; $display("FAIL fwd_no_stall: got %b expected 0", hz.stall);
      end
   endtask

   task automatic test_zero_guard();
      @(negedge clk);
      clr_inputs();
      hz.m_wr_en = 1'b1; hz.m_wa = 5'd0;
      hz.w_wr_en = 1'b1; hz.w_wa = 5'd0;
      hz.d_rs = 5'd0; hz.d_rs_used = 1'b1; hz.d_rs_now = 1'b1;
      hz.e_rs = 5'd0;
      #1;
      checks++;
      if (hz.fwd_d_rs_sel !== 2'b00) begin
         errors++; $display("FAIL zero_fwd_d_rs: got %b expected 00", hz.fwd_d_rs_sel);
      end
      checks++;
      if (hz.fwd_e_rs_sel !== 2'b00) begin
         errors++; $display("FAIL zero_fwd_e_rs: got %b expected 00", hz.fwd_e_rs_sel);
      end
      // load to $0 in E, D reads $0 now: no hazard
      hz.e_is_load = 1'b1; hz.e_wr_en = 1'b1; hz.e_wa = 5'd0;
      hz.d_rt = 5'd0; hz.d_rt_used = 1'b1; hz.d_rt_n_now = 1'b1;
      #1;
      checks++;
      if (hz.stall !== 1'b0) begin
         errors++; $display("FAIL zero_no_stall: got %b expected 0", hz.stall);
      end
   endtask

   task automatic test_load_use();
      // t: lw $9 in E, addu reading rt=$9 in D
      @(negedge clk);
      clr_inputs();
      hz.e_is_load = 1'b1; hz.e_wr_en = 1'b1; hz.e_wa = 5'd9;
      hz.d_rs = 5'd3; hz.d_rs_used = 1'b1;
      hz.d_rt = 5'd9; hz.d_rt_used = 1'b1;
      #1;
      checks++;
      if ({hz.stall, hz.flush_e} !== 2'b11) begin
         errors++; $display("FAIL load_use_stall: got %b expected 11", {hz.stall, hz.flush_e});
      end
      // t+1: load in M, bubble in E, addu held in D
      @(negedge clk);
      clr_inputs();
      hz.m_is_load = 1'b1; hz.m_wr_en = 1'b1; hz.m_wa = 5'd9;
      hz.d_rs = 5'd3; hz.d_rs_used = 1'b1;
      hz.d_rt = 5'd9; hz.d_rt_used = 1'b1;
      #1;
      checks++;
      if ({hz.stall, hz.flush_e} !== 2'b00) begin
         errors++; $display("FAIL load_use_one_cycle: got %b expected 00", {hz.stall, hz.flush_e});
      end
      checks++;
      if (hz.fwd_d_rt_sel !== 2'b00) begin
         errors++; $display("FAIL load_use_no_m_load_fwd: got %b expected 00", hz.fwd_d_rt_sel);
      end
      // t+2: load in W, addu in E
      @(negedge clk);
      clr_inputs();
      hz.w_wr_en = 1'b1; hz.w_wa = 5'd9;
      hz.e_rs = 5'd3; hz.e_rt = 5'd9;
      #1;
      checks++;
      if (hz.fwd_e_rt_sel !== 2'b10) begin
         errors++; $display("FAIL load_use_w_fwd: got %b expected 10", hz.fwd_e_rt_sel);
      end
      checks++;
      if (hz.fwd_e_rs_sel !== 2'b00) begin
         errors++; $display("FAIL load_use_rs_rf: got %b expected 00", hz.fwd_e_rs_sel);
      end
   endtask

   task automatic test_branch();
      @(negedge clk);
      clr_inputs();
      hz.e_wr_en = 1'b1; hz.e_wa = 5'd4;
      hz.d_rs = 5'd4; hz.d_rs_used = 1'b1; hz.d_rs_now = 1'b1;
      hz.d_rt = 5'd5; hz.d_rt_used = 1'b1; hz.d_rt_n_now = 1'b1;
      #1;
      checks++;
      if ({hz.stall, hz.flush_e} !== 2'b11) begin
         errors++; $display("FAIL branch_e_stall: got %b expected 11", {hz.stall, hz.flush_e});
      end
      @(negedge clk);
      hz.e_wr_en = 1'b0; hz.e_wa = 5'd0;
      hz.m_wr_en = 1'b1; hz.m_wa = 5'd4;
      #1;
      checks++;
      if (hz.fwd_d_rs_sel !== 2'b01) begin
         errors++; $display("FAIL branch_m_fwd: got %b expected 01", hz.fwd_d_rs_sel);
      end
      checks++;
      if (hz.stall !== 1'b0) begin
         errors++; $display("FAIL branch_m_no_stall: got %b expected 0", hz.stall);
      end
      // rt operand produced by a load now in M
      hz.m_wa = 5'd5; hz.m_is_load = 1'b1;
      #1;
      checks++;
      if (hz.stall !== 1'b1) begin
         errors++; $display("FAIL branch_rt_m_load_stall: got %b expected 1", hz.stall);
      end
   endtask

   task automatic test_mult_seq();
      @(negedge clk);
      clr_inputs();
      hz.d_is_md = 1'b1;
      hz.start_mult = 1'b1;
      #1;
      checks++;
      if ({hz.stall, hz.md_busy} !== 2'b10) begin
         errors++; $display("FAIL mult_start_cycle: got %b expected 10", {hz.stall, hz.md_busy});
      end
      for (int c = 1; c <= 5; c++) begin
         @(negedge clk);
         hz.start_mult = 1'b0;
         hz.start_div  = (c == 2);
         #1;
         checks++;
         if ({hz.stall, hz.md_busy} !== 2'b11) begin
            errors++; $display("FAIL mult_busy_t%0d: got %b expected 11", c, {hz.stall, hz.md_busy});
         end
      end
      @(negedge clk);
      hz.start_div = 1'b0;
      #1;
      checks++;
      if ({hz.stall, hz.md_busy} !== 2'b00) begin
         errors++; $display("FAIL mult_done_t6: got %b expected 00", {hz.stall, hz.md_busy});
      end
   endtask

   task automatic test_div_wins();
      int busy_cnt;
      busy_cnt = 0;
      @(negedge clk);
      clr_inputs();
      hz.start_mult = 1'b1; hz.start_div = 1'b1;
      for (int c = 1; c <= 13; c++) begin
         @(negedge clk);
         hz.start_mult = 1'b0; hz.start_div = 1'b0;
         #1;
         if (hz.md_busy === 1'b1) busy_cnt++;
      end
      checks++;
      if (busy_cnt != 10) begin
         errors++; $display("FAIL div_wins_length: got %0d busy cycles expected 10", busy_cnt);
      end
   endtask

   task automatic test_reset_mid_div();
      @(negedge clk);
      clr_inputs();
      hz.start_div = 1'b1;
      for (int c = 1; c <= 7; c++) begin
         @(negedge clk);
         hz.start_div = 1'b0;
      end
      // counter is now 4
      #1;
      checks++;
      if (hz.md_busy !== 1'b1) begin
         errors++; $display("FAIL div_busy_before_reset: got %b expected 1", hz.md_busy);
      end
      reset_n = 1'b0;
      #1;
      checks++;
      if (hz.md_busy !== 1'b0) begin
         errors++; $display("FAIL reset_mid_div_async: got %b expected 0", hz.md_busy);
      end
      @(negedge clk);
      reset_n = 1'b1;
      hz.start_mult = 1'b1;
      @(negedge clk);
      hz.start_mult = 1'b0;
      #1;
      checks++;
      if (hz.md_busy !== 1'b1) begin
         errors++; $display("FAIL post_reset_start_accepted: got %b expected 1", hz.md_busy);
      end
      for (int c = 2; c <= 6; c++) @(negedge clk);
      #1;
      checks++;
      if (hz.md_busy !== 1'b0) begin
         errors++; $display("FAIL post_reset_mult_len: got %b expected 0", hz.md_busy);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_fwd_priority();
      test_zero_guard();
      test_load_use();
      test_branch();
      test_mult_seq();
      test_div_wins();
      test_reset_mid_div();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage MIPS core. Each cycle it picks the mux4 select codes for the D-stage and E-stage operand-forwarding muxes. It also raises stall/flush on load-use, branch-operand and HI/LO conflicts. It owns the multiply/divide busy sequencer that blocks HI/LO access until the iterative mult/div unit finishes.

## Interface
Parameters:
- MULT_CYCLES, 5, busy cycles after a mult/multu start
- DIV_CYCLES, 10, busy cycles after a div/divu start

Ports:
- clk  in  1  core clock
- reset_n  in  1  asynchronous, active-low reset
- d_rs, d_rt  in  5 each  D-stage source register numbers
- d_rs_used, d_rt_used  in  1 each  D instruction reads rs/rt at all
- d_rs_now, d_rt_n_now  in  1 each  operand needed in D (branch compare, jr)
- d_is_md  in  1  D instruction is mult/div/mfhi/mflo/mthi/mtlo
- e_rs, e_rt  in  5 each  E-stage source register numbers
- e_wa, m_wa, w_wa  in  5 each  destination register in E/M/W
- e_wr_en, m_wr_en, w_wr_en  in  1 each  stage writes the register file
- e_res_ready  in  1  E result is available in E (lui, jal link)
- e_is_load, m_is_load  in  1 each  stage holds a load
- start_mult, start_div  in  1 each  one-cycle pulse from E when a mult/div issues
- fwd_d_rs_sel, fwd_d_rt_sel  out  2 each  D forwarding mux select
- fwd_e_rs_sel, fwd_e_rt_sel  out  2 each  E forwarding mux select
- stall  out  1  hold PC and the F/D register
- flush_e  out  1  insert bubble into the D/E register
- md_busy  out  1  mult/div unit busy

## Operation
- Select encoding, identical for all four muxes: 2'b00 register-file/pipeline value, 2'b01 M-stage result, 2'b10 W-stage result, 2'b11 E-stage result. E-stage muxes never use 2'b11.
- A producer matches only if its wr_en is 1, its address equals the source, and the source is not $0. $0 always selects 2'b00.
- Priority is nearest stage first: E (D-muxes only, and only if e_res_ready), then M (only if !m_is_load), then W.
- Stall sources, ORed together:
  - load-use: e_is_load, e_wr_en, e_wa≠0, e_wa matches a used D source.
  - branch-now: a d_*_now source matches E (e_wr_en and !e_res_ready) or matches M with m_is_load.
  - md: d_is_md and (md_busy or start_mult or start_div).
- flush_e = stall.
- Sequencer states:
  - IDLE, MULT, DIV, with a down-counter of width clog2(DIV_CYCLES+1).
  - In IDLE, start_mult loads MULT_CYCLES and moves to MULT; start_div loads DIV_CYCLES and moves to DIV. If both pulse together, start_div wins.
  - In MULT/DIV the counter decrements each cycle. When it reaches 1, the state returns to IDLE on the next edge.
  - Starts while not IDLE are ignored; the counter is not reloaded.
- md_busy = (state ≠ IDLE). It is registered.

## Timing
- Reset (reset_n=0, asynchronous): state IDLE, counter 0, md_busy 0. Combinational outputs follow their inputs and are therefore 0 once the stage valids clear. Reset mid-operation aborts the sequence immediately.
- Forwarding selects, stall and flush_e are combinational in the same cycle. md_busy is the only registered output.
- start_mult high in cycle t: md_busy is 1 in cycles t+1 .. t+MULT_CYCLES, and 0 at t+MULT_CYCLES+1. DIV is analogous.
- An mfhi in D during cycle t (the start cycle) already stalls via start_mult.

## Structure
- The shared pipeline package holds:
  - the forwarding select constants FWD_RF, FWD_M, FWD_W, FWD_E;
  - the sequencer state enum;
  - the default MULT_CYCLES/DIV_CYCLES.
- One sub-module, md_seq, holds the sequencer FSM and counter. All forwarding and stall logic stays in the top level.

## Test plan
- Forwarding priority: M writes $8 (ALU) and W writes $8; E reads rs=$8 → fwd_e_rs_sel=2'b01. With m_wr_en=0 → 2'b10.
- $0 guard: M writes $0 and D reads rs=$0 → fwd_d_rs_sel=2'b00, stall=0.
- Load-use: E lw $9; D addu reads rt=$9 → stall=1, flush_e=1 for exactly one cycle. The next cycle fwd_e_rt_sel resolves from M load path only after the load reaches W.
- Branch hazard: E addu $4, D beq on $4 → stall. Next cycle (M holds addu) → fwd_d_rs_sel=2'b01, stall=0.
- Mult sequencing: start_mult at t, mflo in D from t → stall for cycles t..t+5; md_busy falls at t+6. A start_div during busy does not extend the sequence.
- Reset mid-DIV: reset_n low at count 4 → md_busy 0 immediately; after release the state is IDLE.
